demux1_to_8_deser: RTL and testbench

Serial-to-parallel receiver that reassembles 8-bit words from a bit stream produced by an 8:1 selector scanning slots 0..7. Slot k of the incoming stream lands in output bit k, so slot 0 maps to bit 0 and slot 7 maps to bit 7. The block sits at the receive end of the slot-multiplexed link. It hands completed words to downstream logic through a one-entry valid/ready buffer.

---
 rtl/demux1_to_8_deser_pkg.sv | 21 ++
 rtl/demux1_to_8_deser_out_buf.sv | 54 +++++
 rtl/demux1_to_8_deser.sv | 91 +++++++++
 tb/tb_demux1_to_8_deser.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux1_to_8_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux1_to_8_deser_pkg
// Description : Shared constants and helpers for the slot-multiplexed link
//               (mux and deserializer sides use the same slot geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package demux1_to_8_deser_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;
  localparam int WORD_W    = 8;

  // Map a slot index to the word bit it fills, honouring bit ordering.
  function automatic logic [SLOT_W-1:0] slot_to_bit(input logic [SLOT_W-1:0] s,
                                                   input bit msb_first);
    return msb_first ? (SLOT_W'(NUM_SLOTS - 1) - s) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux1_to_8_deser_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : deser_out_buf
// Description : One-entry valid/ready holding register for completed words.
//               A load while the entry is occupied and not draining is
//               dropped and flagged with a one-cycle overrun pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_out_buf
  import demux1_to_8_deser_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;
  logic             w_free;

  // The entry can take a new word if empty or being drained this cycle.
  assign w_free = ~r_valid | ready;

  // Holding register: load wins over drain so back-to-back words keep valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= load & ~w_free;
      if (load && w_free) begin
        r_dout  <= data;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: rtl/demux1_to_8_deser.sv
`default_nettype none
// ============================================================================
// Module      : demux1_to_8_deser
// Description : Serial-to-parallel receiver. Reassembles 8-bit words from a
//               slot-multiplexed bit stream and hands them downstream through
//               a one-entry valid/ready buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1_to_8_deser
  import demux1_to_8_deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [SLOT_W-1:0] slot,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun
);

  localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_SLOTS - 1);

  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [SLOT_W-1:0] w_fill_slot;
  logic [SLOT_W-1:0] w_bitpos;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] w_asm_nxt;
  logic [WORD_W-1:0] w_word;
  logic              w_complete;

  // Next slot/assembly state; sync discards the partial word and restarts at slot 0.
  always_comb begin
    w_fill_slot = sync ? '0 : r_slot;
    w_bitpos    = slot_to_bit(w_fill_slot, MSB_FIRST);
    w_word      = sync ? '0 : r_asm;
    w_word[w_bitpos] = din;
    w_complete  = din_valid & ~sync & (r_slot == c_last_slot);
    w_slot_nxt  = r_slot;
    w_asm_nxt   = r_asm;
    if (sync) begin
      w_slot_nxt = '0;
      w_asm_nxt  = '0;
      if (din_valid) begin
        w_slot_nxt = SLOT_W'(1);
        w_asm_nxt  = w_word;
      end
    end else if (din_valid) begin
      if (w_complete) begin
        w_slot_nxt = '0;
        w_asm_nxt  = '0;
      end else begin
        w_slot_nxt = r_slot + SLOT_W'(1);
        w_asm_nxt  = w_word;
      end
    end
  end

  // Slot counter and assembly register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_asm  <= '0;
    end else begin
      r_slot <= w_slot_nxt;
      r_asm  <= w_asm_nxt;
    end
  end

  assign slot = r_slot;

  deser_out_buf #(
    .WIDTH (WORD_W)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_complete),
    .data       (w_word),
    .ready      (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule
`default_nettype wire

// File: tb/tb_demux1_to_8_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux1_to_8_deser
// Description : Self-checking bench for demux1_to_8_deser. Drives both bit
//               orderings in parallel; expected words go into a queue per
//               instance when the completing bit is driven and are compared
//               against dout while the word is held.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1_to_8_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic       dout_ready = 1'b0;
  logic [2:0] slot_l, slot_m;
  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m, ovr_l, ovr_m;

  int r_errors = 0;
  int r_checks = 0;

  // Reference model state
  logic [2:0] m_slot;
  logic [7:0] m_asm_l, m_asm_m;
  logic       m_valid, m_ovr;
  logic [7:0] q_l[$];
  logic [7:0] q_m[$];

  always #5 clk = ~clk;

  demux1_to_8_deser #(.MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .slot(slot_l), .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .overrun(ovr_l)
  );

  demux1_to_8_deser #(.MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .slot(slot_m), .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .overrun(ovr_m)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    r_checks++;
    if (act !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic rn, input logic v, input logic d, input logic s,
                     input logic rdy);
    logic       complete, free;
    logic [7:0] w_l, w_m;
    rst_n = rn; din_valid = v; din = d; sync = s; dout_ready = rdy;
    if (!rn) begin
      m_slot = '0; m_asm_l = '0; m_asm_m = '0; m_valid = 1'b0; m_ovr = 1'b0;
      q_l.delete(); q_m.delete();
    end else begin
      complete = v & ~s & (m_slot == 3'd7);
      free     = ~m_valid | rdy;
      w_l = m_asm_l; w_l[m_slot] = d;
      w_m = m_asm_m; w_m[3'd7 - m_slot] = d;
      m_ovr = complete & ~free;
      if (m_valid && rdy) begin
        void'(q_l.pop_front()); void'(q_m.pop_front());
        m_valid = 1'b0;
      end
      if (complete && free) begin
        q_l.push_back(w_l); q_m.push_back(w_m);
        m_valid = 1'b1;
      end
      if (s) begin
        m_asm_l = '0; m_asm_m = '0; m_slot = '0;
        if (v) begin m_asm_l[0] = d; m_asm_m[7] = d; m_slot = 3'd1; end
      end else if (v) begin
        if (complete) begin m_asm_l = '0; m_asm_m = '0; m_slot = '0; end
        else begin m_asm_l = w_l; m_asm_m = w_m; m_slot = m_slot + 3'd1; end
      end
    end
    @(posedge clk);
    #1;
    chk("slot_l", 32'(slot_l), 32'(m_slot));
    chk("slot_m", 32'(slot_m), 32'(m_slot));
    chk("valid_l", 32'(dv_l), 32'(m_valid));
    chk("valid_m", 32'(dv_m), 32'(m_valid));
    chk("ovr_l", 32'(ovr_l), 32'(m_ovr));
    chk("ovr_m", 32'(ovr_m), 32'(m_ovr));
    if (m_valid) begin
      chk("sb_nonempty", 32'(q_l.size()), 32'd1);
      if (q_l.size() > 0) chk("dout_l", 32'(dout_l), 32'(q_l[0]));
      if (q_m.size() > 0) chk("dout_m", 32'(dout_m), 32'(q_m[0]));
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, w[k], 1'b0, (k == 7) ? rdy_last : 1'b0);
  endtask

  task automatic drain();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_slot = '0; m_asm_l = '0; m_asm_m = '0; m_valid = 1'b0; m_ovr = 1'b0;

    // Reset
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_slot", 32'(slot_l), 32'd0);
    chk("rst_dout", 32'(dout_l), 32'h00);
    chk("rst_valid", 32'(dv_l), 32'd0);
    chk("rst_ovr", 32'(ovr_l), 32'd0);

    // Basic word: slots 0..7 carry 1,0,1,1,0,0,1,0
    send_word(8'h4D, 1'b0);
    chk("basic_lsb", 32'(dout_l), 32'h4D);
    chk("basic_msb", 32'(dout_m), 32'hB2);
    chk("basic_valid", 32'(dv_l), 32'd1);
    chk("basic_slot", 32'(slot_l), 32'd0);
    drain();
    chk("drain_valid", 32'(dv_l), 32'd0);
    chk("drain_hold", 32'(dout_l), 32'h4D);

    // Back-to-back with consumer stalled: second word dropped
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("ovr_pulse", 32'(ovr_l), 32'd1);
    chk("ovr_dout", 32'(dout_l), 32'hA5);
    chk("ovr_valid", 32'(dv_l), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_once", 32'(ovr_l), 32'd0);
    drain();

    // Sync mid-frame discards three partial 1s
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sync_slot", 32'(slot_l), 32'd1);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_lsb", 32'(dout_l), 32'hFE);
    chk("sync_msb", 32'(dout_m), 32'h7F);
    drain();

    // Completion coincident with drain
    send_word(8'h18, 1'b0);
    send_word(8'h81, 1'b1);
    chk("ovl_dout", 32'(dout_l), 32'h81);
    chk("ovl_valid", 32'(dv_l), 32'd1);
    chk("ovl_ovr", 32'(ovr_l), 32'd0);
    drain();

    // Reset mid-frame, bit on reset cycle must not be stored
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mrst_slot", 32'(slot_l), 32'd0);
    send_word(8'h0F, 1'b0);
    chk("mrst_lsb", 32'(dout_l), 32'h0F);
    chk("mrst_msb", 32'(dout_m), 32'hF0);
    drain();

    // Random traffic
    for (int n = 0; n < 400; n++)
      cyc(1'b1, ($urandom_range(0, 9) != 0), 1'($urandom), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire
